// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: shared prescaler and period counter, per-channel duty, double-buffered updates at wrap.
// Define PWM_CENTER_EN to add the 'center' input for center-aligned (triangle) counting.
module pwm_multi_ch #(
    parameter int CH    = 4,
    parameter int CNT_W = 8,
    parameter int PRE_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
`ifdef PWM_CENTER_EN
    input  logic                center,
`endif
    input  logic [PRE_W-1:0]    prescale,
    input  logic [CNT_W-1:0]    period,
    input  logic [CH*CNT_W-1:0] duty_data,
    input  logic                duty_valid,
    output logic                duty_ready,
    output logic [CH-1:0]       pwm_out,
    output logic                period_end
);

    logic [PRE_W-1:0]    pre_cnt;
    logic [PRE_W-1:0]    act_prescale;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [CNT_W-1:0]    act_period;
    logic [CH*CNT_W-1:0] act_duty;
    logic [CH*CNT_W-1:0] shadow;
    logic                pending;
    logic                accept;
    logic                tick;
    logic                wrap;
    logic                act_center;
    logic                down;

    assign duty_ready = !pending;
    assign accept     = duty_valid && !pending;

    // A down-count wrap lands on cnt=0 itself, so the next cycle resumes at 1 unless the new period is 0.
    always_comb begin
        tick     = ena && (pre_cnt == act_prescale);
        wrap     = 1'b0;
        cnt_next = cnt;
        if (tick) begin
            if (down) begin
                if (cnt == '0) begin
                    wrap     = 1'b1;
                    cnt_next = (period != '0) ? CNT_W'(1) : '0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end else if (cnt == act_period) begin
                if (act_center && (act_period != '0)) begin
                    cnt_next = cnt - CNT_W'(1);
                end else begin
                    wrap     = 1'b1;
                    cnt_next = '0;
                end
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
    end

`ifdef PWM_CENTER_EN
    logic turn;

    assign turn = tick && !down && act_center && (act_period != '0) && (cnt == act_period);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_center <= 1'b0;
            down       <= 1'b0;
        end else begin
            if (wrap) begin
                act_center <= center;
                down       <= 1'b0;
            end else if (turn) begin
                down       <= 1'b1;
            end
        end
    end
`else
    assign act_center = 1'b0;
    assign down       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt      <= '0;
            cnt          <= '0;
            act_period   <= '0;
            act_prescale <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
            cnt     <= cnt_next;
            if (wrap) begin
                act_period   <= period;
                act_prescale <= prescale;
            end
        end else if (ena) begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // Accept and apply are exclusive: accept needs an empty shadow, apply needs a full one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow   <= '0;
            act_duty <= '0;
            pending  <= 1'b0;
        end else if (accept) begin
            shadow  <= duty_data;
            pending <= 1'b1;
        end else if (wrap && pending) begin
            act_duty <= shadow;
            pending  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_end <= 1'b0;
            pwm_out    <= '0;
        end else begin
            period_end <= wrap;
            for (int i = 0; i < CH; i++) begin
                pwm_out[i] <= ena && (cnt < act_duty[i*CNT_W +: CNT_W]);
            end
        end
    end

endmodule
